// File: rtl/tick_debouncer.sv
// tick_debouncer: debounces btn_raw, sampling it once per rising edge of slow_clk (used as data).
// Optional auto-repeat of btn_press while held: define TICK_DEBOUNCER_REPEAT_EN.
module tick_debouncer #(
    parameter int unsigned STABLE_SAMPLES = 4,
    parameter int unsigned REPEAT_DELAY   = 16,
    parameter int unsigned REPEAT_PERIOD  = 4
) (
    input  logic in_clk,
    input  logic rst_n,
    input  logic slow_clk,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int unsigned CNT_W = $clog2(STABLE_SAMPLES + 1);

    typedef enum logic [1:0] {
        S_RELEASED     = 2'd0,
        S_PRESS_PEND   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_PEND = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_slow_q;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             w_level_nxt;
    logic             w_press_nxt;
    logic             w_release_nxt;
    logic             w_tick;
    logic             w_stable;
    logic             w_rep_pulse;

    // slow_clk edge detector and button synchroniser; r_slow_q resets high so no tick on the first cycle
    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slow_q <= 1'b1;
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
        end else begin
            r_slow_q <= slow_clk;
            r_sync1  <= btn_raw;
            r_sync2  <= r_sync1;
        end
    end

    assign w_tick    = slow_clk & ~r_slow_q;
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    // Counter is 0 in the stable states, so this also covers STABLE_SAMPLES == 1 directly from them
    assign w_stable  = (w_cnt_inc == CNT_W'(STABLE_SAMPLES));

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_RELEASED;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt | w_rep_pulse;
            r_release <= w_release_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        if (w_tick) begin
            case (r_state)
                S_RELEASED, S_PRESS_PEND: begin
                    if (r_sync2) begin
                        if (w_stable) begin
                            w_state_nxt = S_PRESSED;
                            w_cnt_nxt   = '0;
                            w_level_nxt = 1'b1;
                            w_press_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_PRESS_PEND;
                            w_cnt_nxt   = w_cnt_inc;
                        end
                    end else begin
                        w_state_nxt = S_RELEASED;
                        w_cnt_nxt   = '0;
                    end
                end
                S_PRESSED, S_RELEASE_PEND: begin
                    if (!r_sync2) begin
                        if (w_stable) begin
                            w_state_nxt   = S_RELEASED;
                            w_cnt_nxt     = '0;
                            w_level_nxt   = 1'b0;
                            w_release_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_RELEASE_PEND;
                            w_cnt_nxt   = w_cnt_inc;
                        end
                    end else begin
                        w_state_nxt = S_PRESSED;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = S_RELEASED;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

`ifdef TICK_DEBOUNCER_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);

    logic [REP_W-1:0] r_rep_cnt;
    logic [REP_W-1:0] w_rep_cnt_nxt;
    logic [REP_W-1:0] w_rep_inc;

    // Ticks since entering PRESSED; after REPEAT_DELAY it cycles DELAY+1..DELAY+PERIOD, pulsing at each wrap
    always_comb begin
        w_rep_cnt_nxt = r_rep_cnt;
        w_rep_pulse   = 1'b0;
        w_rep_inc     = r_rep_cnt + REP_W'(1);
        if (w_state_nxt != S_PRESSED || r_state != S_PRESSED) begin
            w_rep_cnt_nxt = '0;
        end else if (w_tick) begin
            if (w_rep_inc == REP_W'(REPEAT_DELAY + REPEAT_PERIOD)) begin
                w_rep_cnt_nxt = REP_W'(REPEAT_DELAY);
                w_rep_pulse   = 1'b1;
            end else begin
                w_rep_cnt_nxt = w_rep_inc;
                w_rep_pulse   = (w_rep_inc == REP_W'(REPEAT_DELAY));
            end
        end
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_cnt <= '0;
        end else begin
            r_rep_cnt <= w_rep_cnt_nxt;
        end
    end
`else
    logic w_unused_repeat;

    assign w_rep_pulse     = 1'b0;
    assign w_unused_repeat = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;

endmodule

// File: tb/tb_tick_debouncer.sv
// Scoreboard bench for tick_debouncer: stimulus queues expected pulses (kind + tick index), a monitor pops and compares.
module tb_tick_debouncer;

    typedef struct {
        bit is_press;
        int tick;
    } exp_t;

    logic in_clk = 1'b0;
    logic rst_n  = 1'b0;
    logic slow_clk = 1'b0;
    logic btn_raw  = 1'b0;
    logic btn_level;
    logic btn_press;
    logic btn_release;

    bit   slow_en   = 1'b1;
    logic slow_prev = 1'b1;
    int   tick_cnt  = 0;
    int   checks    = 0;
    int   failures  = 0;
    exp_t exp_q[$];

    tick_debouncer #(
        .STABLE_SAMPLES(4),
        .REPEAT_DELAY  (16),
        .REPEAT_PERIOD (4)
    ) dut (
        .in_clk     (in_clk),
        .rst_n      (rst_n),
        .slow_clk   (slow_clk),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #5 in_clk = ~in_clk;

    // slow_clk: period of 10 in_clk cycles, freezable
    initial begin
        forever begin
            repeat (5) @(negedge in_clk);
            if (slow_en) slow_clk = ~slow_clk;
        end
    end

    // Bench-side tick index: bumped on the in_clk edge where the DUT sees a slow_clk rise
    always @(posedge in_clk) begin
        if (slow_clk && !slow_prev) tick_cnt <= tick_cnt + 1;
        slow_prev <= slow_clk;
    end

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic push_ev(input bit is_press, input int tick);
        exp_t e;
        e.is_press = is_press;
        e.tick     = tick;
        exp_q.push_back(e);
    endtask

    // Returns at the negedge following the n-th next tick
    task automatic after_ticks(input int n);
        int tgt;
        int budget;
        tgt    = tick_cnt + n;
        budget = n * 10 + 20;
        while (tick_cnt != tgt && budget > 0) begin
            @(negedge in_clk);
            budget--;
        end
        if (tick_cnt != tgt) begin
            checks++;
            failures++;
            $display("FAIL tick_wait: tick %0d expected %0d", tick_cnt, tgt);
        end
    endtask

    // Monitor: every pulse must match the head of the expected queue
    initial begin
        bit   prev_p;
        bit   prev_r;
        exp_t e;
        prev_p = 1'b0;
        prev_r = 1'b0;
        forever begin
            @(negedge in_clk);
            if (btn_press === 1'b1 || btn_release === 1'b1) begin
                checks++;
                if (btn_press && btn_release) begin
                    failures++;
                    $display("FAIL both_pulses: press=%0b release=%0b expected only one", btn_press, btn_release);
                end else if ((btn_press && prev_p) || (btn_release && prev_r)) begin
                    failures++;
                    $display("FAIL pulse_width: pulse still high at tick %0d, expected one cycle", tick_cnt);
                end else if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse: press=%0b release=%0b at tick %0d, expected none",
                             btn_press, btn_release, tick_cnt);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_press != btn_press || e.tick != tick_cnt || btn_level !== btn_press) begin
                        failures++;
                        $display("FAIL event: press=%0b tick=%0d level=%0b expected press=%0b tick=%0d level=%0b",
                                 btn_press, tick_cnt, btn_level, e.is_press, e.tick, e.is_press);
                    end
                end
            end
            prev_p = btn_press;
            prev_r = btn_release;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tr;
        int tb;
        int tg;
        int tq;
        int te;

        // Reset held with button pressed and slow_clk running
        btn_raw = 1'b1;
        after_ticks(20);
        chk("reset_level", btn_level, 1'b0);
        chk("reset_press", btn_press, 1'b0);
        chk("reset_release", btn_release, 1'b0);

        // Release reset: clean press needs 4 ticks of btn_sync=1
        rst_n = 1'b1;
        tr = tick_cnt;
        push_ev(1'b1, tr + 4);
        @(negedge in_clk);
        chk("first_cycle_press", btn_press, 1'b0);
        chk("first_cycle_release", btn_release, 1'b0);
        after_ticks(5);
        chk("press_level", btn_level, 1'b1);

        // Clean release
        btn_raw = 1'b0;
        push_ev(1'b0, tr + 9);
        after_ticks(5);
        chk("release_level", btn_level, 1'b0);

        // Bounce: 3 ones, 1 zero, then 4 more ones before the press
        tb = tick_cnt;
        push_ev(1'b1, tb + 8);
        btn_raw = 1'b1;
        after_ticks(3);
        btn_raw = 1'b0;
        after_ticks(1);
        chk("bounce_level_low", btn_level, 1'b0);
        btn_raw = 1'b1;
        after_ticks(5);
        chk("bounce_level_high", btn_level, 1'b1);

        // One-tick low glitch while pressed: no release
        tg = tick_cnt;
        btn_raw = 1'b0;
        after_ticks(1);
        btn_raw = 1'b1;
        after_ticks(2);
        chk("glitch_low_level", btn_level, 1'b1);
        btn_raw = 1'b0;
        push_ev(1'b0, tg + 7);
        after_ticks(5);
        chk("release2_level", btn_level, 1'b0);

        // One-tick high glitch while released: no press
        btn_raw = 1'b1;
        after_ticks(1);
        btn_raw = 1'b0;
        after_ticks(3);
        chk("glitch_high_level", btn_level, 1'b0);

        // Reset in PRESS_PEND after 2 ticks: progress discarded
        btn_raw = 1'b1;
        after_ticks(2);
        rst_n = 1'b0;
        #1;
        chk("midreset_level", btn_level, 1'b0);
        chk("midreset_press", btn_press, 1'b0);
        @(negedge in_clk);
        @(negedge in_clk);
        rst_n = 1'b1;
        tq = tick_cnt;
        te = tq + 4;
        push_ev(1'b1, te);

        // Hold 30 ticks in PRESSED, then release
`ifdef TICK_DEBOUNCER_REPEAT_EN
        push_ev(1'b1, te + 16);
        push_ev(1'b1, te + 20);
        push_ev(1'b1, te + 24);
        push_ev(1'b1, te + 28);
`endif
        after_ticks(4 + 30);
        chk("hold_level", btn_level, 1'b1);
        btn_raw = 1'b0;
        push_ev(1'b0, te + 34);
        after_ticks(6);
        chk("hold_release_level", btn_level, 1'b0);

        // Frozen slow_clk: pressing must change nothing
        slow_en = 1'b0;
        btn_raw = 1'b1;
        repeat (100) @(negedge in_clk);
        chk("frozen_level", btn_level, 1'b0);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_events: %0d pending expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
